// File: rtl/vreg_writeback.sv
// Vector register writeback: turns arithmetic result beats into byte-masked register-file writes.
// Build option WB_SKID_EN selects a 2-entry FIFO with registered in_ready; otherwise a 1-entry register.
module vreg_writeback (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [4:0]   in_vd,
    input  logic [1:0]   in_vsew,
    input  logic [4:0]   in_elem_count,
    input  logic         in_first,
    input  logic         in_last,
    input  logic         in_reduction,
    output logic         wr_en,
    input  logic         wr_ready,
    output logic [4:0]   wr_addr,
    output logic [127:0] wr_data,
    output logic [15:0]  wr_be,
    output logic         done
);

    typedef struct packed {
        logic [4:0]   addr;
        logic [127:0] data;
        logic [15:0]  be;
        logic         last;
    } wb_entry_t;

    logic [4:0]  offset_q;
    logic [4:0]  eff_off;
    logic [1:0]  vsew_eff;
    logic [4:0]  ec_clamp;
    logic [6:0]  span;
    logic [4:0]  nbytes;
    logic [16:0] mask;
    wb_entry_t   in_entry;
    wb_entry_t   head;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        vsew_eff = (in_vsew == 2'd3) ? 2'd2 : in_vsew;
        ec_clamp = (in_elem_count > 5'd16) ? 5'd16 : in_elem_count;
        span     = {2'b00, ec_clamp} << vsew_eff;
        if (in_reduction)
            nbytes = 5'd1 << vsew_eff;
        else if (span > 7'd16)
            nbytes = 5'd16;
        else
            nbytes = span[4:0];
        // One extra bit so a full 16-byte count yields 0xFFFF after the subtract.
        mask          = (17'd1 << nbytes) - 17'd1;
        eff_off       = in_first ? 5'd0 : offset_q;
        in_entry.addr = in_vd + eff_off;
        in_entry.data = in_data;
        in_entry.be   = mask[15:0];
        in_entry.last = in_last;
    end

    assign accept = in_valid & in_ready;
    assign push   = accept & (nbytes != 5'd0);
    assign pop    = wr_en & wr_ready;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            offset_q <= 5'd0;
            done     <= 1'b0;
        end else begin
            if (accept)
                offset_q <= eff_off + 5'd1;
            // Zero-byte beats never enter the buffer, so their completion is signalled at acceptance.
            done <= (pop & head.last) | (accept & (nbytes == 5'd0) & in_last);
        end
    end

`ifdef WB_SKID_EN
    wb_entry_t mem [2];
    logic      rd_ptr;
    logic      wr_ptr;
    logic [1:0] count;
    logic [1:0] count_next;
    logic      in_ready_q;

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 2; i++)
                mem[i] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count      <= count_next;
            in_ready_q <= (count_next < 2'd2);
        end
    end

    assign head     = mem[rd_ptr];
    assign wr_en    = (count != 2'd0);
    assign in_ready = in_ready_q;
`else
    wb_entry_t slot;
    logic      slot_vld;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            slot     <= '0;
            slot_vld <= 1'b0;
        end else if (push) begin
            slot     <= in_entry;
            slot_vld <= 1'b1;
        end else if (pop) begin
            slot_vld <= 1'b0;
        end
    end

    assign head     = slot;
    assign wr_en    = slot_vld;
    assign in_ready = !slot_vld | wr_ready;
`endif

    assign wr_addr = head.addr;
    assign wr_data = head.data;
    assign wr_be   = head.be;

endmodule
